// File: rtl/id_ex_pipe_reg_pkg.sv
// Shared decode constants and the ID/EX control bundle.
// Used by the decoder and by the ID/EX register.
package id_ex_pipe_reg_pkg;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_SD    = 7'b0100011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_OPIMM = 7'b0010011;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_e;

  typedef struct packed {
    logic       reg_write;
    logic       alu_src;
    logic       branch;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic [1:0] alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/id_ex_pipe_reg_load_use.sv
// Combinational load-use hazard detect between
// the load in EX and the instruction in ID.
module load_use_detect (
  input  logic       id_valid_i,
  input  logic       flush_i,
  input  logic       ex_valid_i,
  input  logic       ex_mem_read_i,
  input  logic [4:0] ex_rd_i,
  input  logic [4:0] rs1_i,
  input  logic [4:0] rs2_i,
  input  logic       alu_src_i,
  input  logic       mem_write_i,
  output logic       stall_o
);

  logic hit1;
  logic hit2;

  assign hit1 = (ex_rd_i == rs1_i);
  // rs2 is a real source only for R-format, beq and sd
  assign hit2 = (ex_rd_i == rs2_i) & (~alu_src_i | mem_write_i);

  assign stall_o = ~flush_i & id_valid_i & ex_valid_i
                 & ex_mem_read_i & (|ex_rd_i)
                 & (hit1 | hit2);

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with load-use stall,
// bubble insertion on hazard/flush and a bubble counter.
module id_ex_pipe_reg
  import id_ex_pipe_reg_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_valid_i,
  input  logic              RegWrite_i,
  input  logic              ALUSrc_i,
  input  logic              Branch_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic              MemtoReg_i,
  input  logic [1:0]        ALU_op_i,
  input  logic [3:0]        funct_i,
  input  logic [4:0]        rs1_addr_i,
  input  logic [4:0]        rs2_addr_i,
  input  logic [4:0]        rd_addr_i,
  input  logic [DATA_W-1:0] rs1_data_i,
  input  logic [DATA_W-1:0] rs2_data_i,
  input  logic [DATA_W-1:0] imm_i,
  input  logic [DATA_W-1:0] pc_i,
  input  logic              flush_i,
  output logic              ex_valid_o,
  output logic              ex_RegWrite_o,
  output logic              ex_ALUSrc_o,
  output logic              ex_Branch_o,
  output logic              ex_MemRead_o,
  output logic              ex_MemWrite_o,
  output logic              ex_MemtoReg_o,
  output logic [1:0]        ex_ALU_op_o,
  output logic [3:0]        ex_funct_o,
  output logic [4:0]        ex_rs1_addr_o,
  output logic [4:0]        ex_rs2_addr_o,
  output logic [4:0]        ex_rd_addr_o,
  output logic [DATA_W-1:0] ex_rs1_data_o,
  output logic [DATA_W-1:0] ex_rs2_data_o,
  output logic [DATA_W-1:0] ex_imm_o,
  output logic [DATA_W-1:0] ex_pc_o,
  output logic              stall_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
);

  logic              valid_q, valid_d;
  ctrl_t             ctrl_q, ctrl_d;
  logic [3:0]        funct_q, funct_d;
  logic [4:0]        rs1_q, rs1_d;
  logic [4:0]        rs2_q, rs2_d;
  logic [4:0]        rd_q, rd_d;
  logic [DATA_W-1:0] rs1_data_q, rs1_data_d;
  logic [DATA_W-1:0] rs2_data_q, rs2_data_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic stall;
  logic load_en;
  logic bubble_ins;

  load_use_detect u_lud (
    .id_valid_i    (id_valid_i),
    .flush_i       (flush_i),
    .ex_valid_i    (valid_q),
    .ex_mem_read_i (ctrl_q.mem_read),
    .ex_rd_i       (rd_q),
    .rs1_i         (rs1_addr_i),
    .rs2_i         (rs2_addr_i),
    .alu_src_i     (ALUSrc_i),
    .mem_write_i   (MemWrite_i),
    .stall_o       (stall)
  );

  assign load_en    = id_valid_i & ~flush_i & ~stall;
  assign bubble_ins = flush_i | stall;

  always_comb begin
    valid_d    = 1'b0;
    ctrl_d     = CTRL_NOP;
    funct_d    = '0;
    rs1_d      = '0;
    rs2_d      = '0;
    rd_d       = '0;
    rs1_data_d = '0;
    rs2_data_d = '0;
    imm_d      = '0;
    pc_d       = '0;
    if (load_en) begin
      valid_d           = 1'b1;
      ctrl_d.reg_write  = RegWrite_i;
      ctrl_d.alu_src    = ALUSrc_i;
      ctrl_d.branch     = Branch_i;
      ctrl_d.mem_read   = MemRead_i;
      ctrl_d.mem_write  = MemWrite_i;
      // decoder leaves MemtoReg don't-care when nothing is written
      ctrl_d.mem_to_reg = MemtoReg_i & RegWrite_i;
      ctrl_d.alu_op     = ALU_op_i;
      funct_d           = funct_i;
      rs1_d             = rs1_addr_i;
      rs2_d             = rs2_addr_i;
      rd_d              = rd_addr_i;
      rs1_data_d        = rs1_data_i;
      rs2_data_d        = rs2_data_i;
      imm_d             = imm_i;
      pc_d              = pc_i;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (bubble_ins && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q    <= 1'b0;
      ctrl_q     <= CTRL_NOP;
      funct_q    <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      pc_q       <= '0;
      cnt_q      <= '0;
    end else begin
      valid_q    <= valid_d;
      ctrl_q     <= ctrl_d;
      funct_q    <= funct_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      imm_q      <= imm_d;
      pc_q       <= pc_d;
      cnt_q      <= cnt_d;
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (!rst_i && load_en) begin
      assert (!$isunknown({RegWrite_i, ALUSrc_i, Branch_i,
                           MemRead_i, MemWrite_i, ALU_op_i}))
        else $error("decoder drove X control on valid instr");
    end
  end
`endif

  assign ex_valid_o    = valid_q;
  assign ex_RegWrite_o = ctrl_q.reg_write;
  assign ex_ALUSrc_o   = ctrl_q.alu_src;
  assign ex_Branch_o   = ctrl_q.branch;
  assign ex_MemRead_o  = ctrl_q.mem_read;
  assign ex_MemWrite_o = ctrl_q.mem_write;
  assign ex_MemtoReg_o = ctrl_q.mem_to_reg;
  assign ex_ALU_op_o   = ctrl_q.alu_op;
  assign ex_funct_o    = funct_q;
  assign ex_rs1_addr_o = rs1_q;
  assign ex_rs2_addr_o = rs2_q;
  assign ex_rd_addr_o  = rd_q;
  assign ex_rs1_data_o = rs1_data_q;
  assign ex_rs2_data_o = rs2_data_q;
  assign ex_imm_o      = imm_q;
  assign ex_pc_o       = pc_q;
  assign stall_o       = stall;
  assign bubble_cnt_o  = cnt_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed scoreboard bench for id_ex_pipe_reg.
// Expected EX entries are queued at drive time and checked after the edge.
module tb_id_ex_pipe_reg;

  typedef struct packed {
    logic        v;
    logic        rw, as, br, mr, mw, mtr;
    logic [1:0]  op;
    logic [3:0]  fn;
    logic [4:0]  r1, r2, rd;
    logic [63:0] d1, d2, imm, pc;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_valid = 1'b0;
  logic        rw = 1'b0, as = 1'b0, br = 1'b0;
  logic        mr = 1'b0, mw = 1'b0, mtr = 1'b0;
  logic [1:0]  op = '0;
  logic [3:0]  fn = '0;
  logic [4:0]  r1 = '0, r2 = '0, rd = '0;
  logic [63:0] d1 = '0, d2 = '0, imm = '0, pc = '0;
  logic        flush = 1'b0;

  logic        o_v, o_rw, o_as, o_br, o_mr, o_mw, o_mtr;
  logic [1:0]  o_op;
  logic [3:0]  o_fn;
  logic [4:0]  o_r1, o_r2, o_rd;
  logic [63:0] o_d1, o_d2, o_imm, o_pc;
  logic        stall;
  logic [15:0] cnt;

  int checks = 0;
  int failures = 0;
  ent_t sb[$];
  logic [15:0] mcnt = '0;
  logic [63:0] pcv = 64'h1000;

  always #5 clk = ~clk;

  id_ex_pipe_reg dut (
    .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid),
    .RegWrite_i(rw), .ALUSrc_i(as), .Branch_i(br),
    .MemRead_i(mr), .MemWrite_i(mw), .MemtoReg_i(mtr),
    .ALU_op_i(op), .funct_i(fn),
    .rs1_addr_i(r1), .rs2_addr_i(r2), .rd_addr_i(rd),
    .rs1_data_i(d1), .rs2_data_i(d2), .imm_i(imm), .pc_i(pc),
    .flush_i(flush),
    .ex_valid_o(o_v), .ex_RegWrite_o(o_rw), .ex_ALUSrc_o(o_as),
    .ex_Branch_o(o_br), .ex_MemRead_o(o_mr), .ex_MemWrite_o(o_mw),
    .ex_MemtoReg_o(o_mtr), .ex_ALU_op_o(o_op), .ex_funct_o(o_fn),
    .ex_rs1_addr_o(o_r1), .ex_rs2_addr_o(o_r2), .ex_rd_addr_o(o_rd),
    .ex_rs1_data_o(o_d1), .ex_rs2_data_o(o_d2),
    .ex_imm_o(o_imm), .ex_pc_o(o_pc),
    .stall_o(stall), .bubble_cnt_o(cnt)
  );

  task automatic chk(input string tag, input logic [63:0] ob,
                     input logic [63:0] ex);
    checks++;
    assert (ob === ex) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, ob, ex);
    end
  endtask

  function automatic ent_t obs();
    ent_t o;
    o = {o_v, o_rw, o_as, o_br, o_mr, o_mw, o_mtr, o_op, o_fn,
         o_r1, o_r2, o_rd, o_d1, o_d2, o_imm, o_pc};
    return o;
  endfunction

  function automatic ent_t i_r(input logic [4:0] d, s1, s2,
                               input logic [63:0] v1, v2);
    ent_t e = '0;
    e.v = 1; e.rw = 1; e.op = 2'b10;
    e.rd = d; e.r1 = s1; e.r2 = s2; e.d1 = v1; e.d2 = v2;
    return e;
  endfunction

  function automatic ent_t i_ld(input logic [4:0] d, s1,
                                input logic [63:0] im);
    ent_t e = '0;
    e.v = 1; e.rw = 1; e.as = 1; e.mr = 1; e.mtr = 1;
    e.fn = 4'b0011; e.rd = d; e.r1 = s1; e.r2 = 5'd0;
    e.imm = im; e.d1 = 64'h2000;
    return e;
  endfunction

  function automatic ent_t i_addi(input logic [4:0] d, s1, f2,
                                  input logic [63:0] im);
    ent_t e = '0;
    e.v = 1; e.rw = 1; e.as = 1; e.op = 2'b10;
    e.rd = d; e.r1 = s1; e.r2 = f2; e.imm = im;
    e.d1 = 64'h33; e.d2 = 64'h44;
    return e;
  endfunction

  function automatic ent_t i_sd(input logic [4:0] s2, s1,
                                input logic [63:0] im);
    ent_t e = '0;
    e.v = 1; e.as = 1; e.mw = 1; e.mtr = 1'bx;
    e.fn = 4'b0011; e.r1 = s1; e.r2 = s2; e.rd = 5'd8;
    e.imm = im; e.d1 = 64'h3000; e.d2 = 64'hdead_beef;
    return e;
  endfunction

  task automatic drive(input ent_t e, input logic fl);
    id_valid = e.v; rw = e.rw; as = e.as; br = e.br;
    mr = e.mr; mw = e.mw; mtr = e.mtr; op = e.op; fn = e.fn;
    r1 = e.r1; r2 = e.r2; rd = e.rd;
    d1 = e.d1; d2 = e.d2; imm = e.imm; pc = e.pc;
    flush = fl;
  endtask

  task automatic step(input string tag, input ent_t ein,
                      input logic fl, input logic xs);
    ent_t e, x, o;
    e = ein;
    e.pc = pcv;
    @(negedge clk);
    drive(e, fl);
    #1;
    chk({tag, "_stall"}, {63'd0, stall}, {63'd0, xs});
    if (fl || xs || !e.v) begin
      x = '0;
    end else begin
      x = e;
      x.v = 1'b1;
      x.mtr = e.mtr & e.rw;
      pcv = pcv + 64'd4;
    end
    sb.push_back(x);
    if ((fl || xs) && mcnt != 16'hFFFF) mcnt = mcnt + 16'd1;
    @(posedge clk);
    #1;
    x = sb.pop_front();
    o = obs();
    checks++;
    assert (o === x) else begin
      failures++;
      $error("FAIL %s_ex observed=%h expected=%h", tag, o, x);
    end
    chk({tag, "_cnt"}, {48'd0, cnt}, {48'd0, mcnt});
  endtask

  initial begin
    ent_t g;
    #3;
    chk("rst_valid", {63'd0, o_v}, 64'd0);
    chk("rst_stall", {63'd0, stall}, 64'd0);
    chk("rst_cnt", {48'd0, cnt}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    step("add_x3", i_r(3, 1, 2, 64'd5, 64'd7), 0, 0);
    step("ld_x5", i_ld(5, 1, 64'd0), 0, 0);
    step("addi_haz", i_addi(6, 5, 1, 64'd1), 0, 1);
    step("addi_go", i_addi(6, 5, 1, 64'd1), 0, 0);

    step("ld_x5b", i_ld(5, 1, 64'd0), 0, 0);
    step("addi_rs2f", i_addi(6, 1, 5, 64'd5), 0, 0);
    step("ld_x5c", i_ld(5, 1, 64'd0), 0, 0);
    step("sd_haz", i_sd(5, 1, 64'd0), 0, 1);
    step("sd_go", i_sd(5, 1, 64'd0), 0, 0);

    step("ld_x0", i_ld(0, 1, 64'd0), 0, 0);
    step("add_x0", i_r(1, 0, 0, 64'd0, 64'd0), 0, 0);

    step("ld_x5d", i_ld(5, 1, 64'd0), 0, 0);
    step("flush_haz", i_r(7, 5, 5, 64'd1, 64'd2), 1, 0);

    step("ld_a", i_ld(5, 1, 64'd0), 0, 0);
    step("ld_b_haz", i_ld(6, 5, 64'd0), 0, 1);
    step("ld_b_go", i_ld(6, 5, 64'd0), 0, 0);
    step("add_haz", i_r(7, 6, 0, 64'd9, 64'd0), 0, 1);
    step("add_go", i_r(7, 6, 0, 64'd9, 64'd0), 0, 0);

    g = {$urandom, $urandom, $urandom, $urandom, $urandom,
         $urandom, $urandom, $urandom, $urandom};
    g.v = 1'b0;
    step("invalid", g, 0, 0);

    step("ld_prerst", i_ld(5, 1, 64'd8), 0, 0);
    @(negedge clk);
    drive(i_addi(6, 5, 1, 64'd1), 0);
    #1;
    chk("prerst_stall", {63'd0, stall}, 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_valid", {63'd0, o_v}, 64'd0);
    chk("midrst_stall", {63'd0, stall}, 64'd0);
    chk("midrst_cnt", {48'd0, cnt}, 64'd0);
    chk("midrst_rd", {59'd0, o_rd}, 64'd0);
    chk("midrst_imm", o_imm, 64'd0);
    sb.delete();
    mcnt = '0;
    @(negedge clk);
    rst = 1'b0;

    step("post_rst", i_r(3, 1, 2, 64'd11, 64'd12), 0, 0);

    @(negedge clk);
    drive(i_r(1, 2, 3, 64'd1, 64'd1), 1);
    repeat (65534) @(posedge clk);
    #1;
    chk("sat_fffe", {48'd0, cnt}, 64'hFFFE);
    @(posedge clk);
    #1;
    chk("sat_ffff", {48'd0, cnt}, 64'hFFFF);
    @(posedge clk);
    #1;
    chk("sat_hold", {48'd0, cnt}, 64'hFFFF);
    chk("sat_valid", {63'd0, o_v}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
